// File: rtl/mul_booth_datapath_if.sv
// Operand, control and product bundle between the multiplier FSM side and
// the Booth datapath.
interface mul_booth_datapath_if;
  logic        state;
  logic        op_start;
  logic        op_clear;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] count;
  logic [63:0] result;

  modport master (
    output state, op_start, op_clear, multiplicand, multiplier,
    input  count, result
  );

  modport slave (
    input  state, op_start, op_clear, multiplicand, multiplier,
    output count, result
  );
endinterface

// File: rtl/mul_booth_datapath.sv
// Sequential 32x32->64 multiplier datapath, one step per clock in EXEC.
// MUL_SIGNED_EN selects radix-2 Booth (signed); otherwise unsigned shift-add.
module mul_booth_datapath (
  input  logic                 clk,
  input  logic                 reset_n,
  mul_booth_datapath_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e      cur_state;
  logic [31:0] m_reg;
  logic [63:0] result_q;
  logic [31:0] count_q;
  logic [31:0] a_half;
  logic [32:0] sum;
`ifdef MUL_SIGNED_EN
  logic        q_m1;
`endif

  assign cur_state  = state_e'(bus.state);
  assign a_half     = result_q[63:32];
  assign bus.count  = count_q;
  assign bus.result = result_q;

  always_comb begin
    sum = {1'b0, a_half};
`ifdef MUL_SIGNED_EN
    case ({result_q[0], q_m1})
      2'b01:   sum = {a_half[31], a_half} + {m_reg[31], m_reg};
      2'b10:   sum = {a_half[31], a_half} - {m_reg[31], m_reg};
      default: sum = {a_half[31], a_half};
    endcase
`else
    if (result_q[0]) sum = {1'b0, a_half} + {1'b0, m_reg};
`endif
  end

  // The 33-bit sum already carries the correct top bit, so {sum, Q[31:1]}
  // is the arithmetic (signed) or logical (unsigned) shift in both builds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      result_q <= '0;
      m_reg    <= '0;
`ifdef MUL_SIGNED_EN
      q_m1     <= 1'b0;
`endif
    end else if (bus.op_clear) begin
      count_q  <= '0;
      result_q <= '0;
      m_reg    <= '0;
`ifdef MUL_SIGNED_EN
      q_m1     <= 1'b0;
`endif
    end else if (cur_state == IDLE && bus.op_start) begin
      m_reg    <= bus.multiplicand;
      result_q <= {32'h0, bus.multiplier};
      count_q  <= '0;
`ifdef MUL_SIGNED_EN
      q_m1     <= 1'b0;
`endif
    end else if (cur_state == EXEC && !count_q[31]) begin
      result_q <= {sum, result_q[31:1]};
      count_q  <= {count_q[30:0], 1'b1};
`ifdef MUL_SIGNED_EN
      q_m1     <= result_q[0];
`endif
    end
  end

endmodule

// File: tb/tb_mul_booth_datapath.sv
// Self-checking bench for mul_booth_datapath: arithmetic reference model plus
// directed vectors with literal products for the build selected by MUL_SIGNED_EN.
module tb_mul_booth_datapath;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mul_booth_datapath_if bus ();

  mul_booth_datapath dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference: loaded operands plus number of steps taken since load/clear.
  logic [31:0] mm = '0;
  logic [31:0] mq = '0;
  int          msteps = 0;

  function automatic logic [63:0] prod(input logic [31:0] m, input logic [31:0] q);
`ifdef MUL_SIGNED_EN
    logic signed [63:0] ms, qs;
    ms = {{32{m[31]}}, m};
    qs = {{32{q[31]}}, q};
    return ms * qs;
`else
    return {32'h0, m} * {32'h0, q};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge reset_n) begin
    mm = '0;
    mq = '0;
    msteps = 0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.op_clear) begin
        mm = '0;
        mq = '0;
        msteps = 0;
      end else if (!bus.state && bus.op_start) begin
        mm = bus.multiplicand;
        mq = bus.multiplier;
        msteps = 0;
      end else if (bus.state && msteps < 32) begin
        msteps++;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp_cnt;
    exp_cnt = ((64'd1 << msteps) - 64'd1) & 64'hFFFF_FFFF;
    chk("count", {32'h0, bus.count}, exp_cnt);
    if (msteps == 0)
      chk("result_loaded", bus.result, {32'h0, mq});
    else if (msteps == 32)
      chk("result_final", bus.result, prod(mm, mq));
  end

  task automatic load(input logic [31:0] m, input logic [31:0] q);
    @(negedge clk);
    bus.state        = 1'b0;
    bus.op_start     = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.op_start     = 1'b0;
  endtask

  task automatic run_done(input string name, input logic [63:0] lit);
    logic ok;
    ok = 1'b0;
    bus.state = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.count[31]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {63'h0, ok}, 64'h1);
    chk({name, "_count"}, {32'h0, bus.count}, 64'hFFFF_FFFF);
    chk(name, bus.result, lit);
  endtask

  logic [31:0] tm [4];
  logic [31:0] tq [4];
  logic [63:0] tp [4];

  initial begin
    tm[0] = 32'hFFFF_FFFA; tq[0] = 32'd7;
    tm[1] = 32'h8000_0000; tq[1] = 32'h8000_0000;
    tm[2] = 32'hFFFF_FFFF; tq[2] = 32'hFFFF_FFFF;
    tm[3] = 32'h0;         tq[3] = 32'hFFFF_FFFF;
`ifdef MUL_SIGNED_EN
    tp[0] = 64'hFFFF_FFFF_FFFF_FFD6;
    tp[1] = 64'h4000_0000_0000_0000;
    tp[2] = 64'h0000_0000_0000_0001;
    tp[3] = 64'h0;
`else
    tp[0] = 64'h0000_0006_FFFF_FFD6;
    tp[1] = 64'h4000_0000_0000_0000;
    tp[2] = 64'hFFFF_FFFE_0000_0001;
    tp[3] = 64'h0;
`endif

    bus.state        = 1'b0;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_count", {32'h0, bus.count}, 64'h0);
    chk("reset_result", bus.result, 64'h0);
    #9 reset_n = 1'b1;

    // 6 * 7, then hold in done
    load(32'd6, 32'd7);
    run_done("m6_q7", 64'h2A);
    repeat (5) @(negedge clk);
    chk("hold_result", bus.result, 64'h2A);
    chk("hold_count", {32'h0, bus.count}, 64'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      load(tm[i], tq[i]);
      run_done("table", tp[i]);
    end

    // op_clear after step 10, then reload
    load(32'd123, 32'd456);
    bus.state = 1'b1;
    repeat (10) @(negedge clk);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    bus.state = 1'b0;
    chk("clear_count", {32'h0, bus.count}, 64'h0);
    chk("clear_result", bus.result, 64'h0);
    load(32'd123, 32'd456);
    run_done("after_clear", 64'd56088);

    // asynchronous reset during step 17, away from any clock edge
    load(32'h1234, 32'h5678);
    bus.state = 1'b1;
    repeat (16) @(negedge clk);
    #1 reset_n = 1'b0;
    bus.state = 1'b0;
    #1;
    chk("async_rst_count", {32'h0, bus.count}, 64'h0);
    chk("async_rst_result", bus.result, 64'h0);
    #2 reset_n = 1'b1;

    // op_start in EXEC at step 5 ignored; operand inputs changed mid-run
    load(32'd1000, 32'd2000);
    bus.state = 1'b1;
    repeat (4) @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = 32'hDEAD;
    bus.multiplier   = 32'hBEEF;
    @(negedge clk);
    bus.op_start = 1'b0;
    bus.multiplier = 32'h7;
    run_done("start_in_exec", 64'd2000000);

    // op_start together with op_clear in IDLE: clear wins
    @(negedge clk);
    bus.state        = 1'b0;
    bus.op_start     = 1'b1;
    bus.op_clear     = 1'b1;
    bus.multiplicand = 32'h55;
    bus.multiplier   = 32'h66;
    @(negedge clk);
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    chk("clear_vs_start_count", {32'h0, bus.count}, 64'h0);
    chk("clear_vs_start_result", bus.result, 64'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_booth_datapath.md
# mul_booth_datapath

Sequential 32×32→64 multiplier datapath driven by the multiplier control FSM. It loads operands on `op_start`, then performs one radix-2 Booth step per clock while the FSM is in EXEC. It produces the 32-bit thermometer step counter `count` that the next-state logic monitors (done when `count[31]`=1) and the 64-bit product. It sits directly upstream of `mul_next_state`, whose `count` input it drives, and shares the FSM state register output `state`.

## Interface
- No parameters; width fixed at 32-bit operands, 64-bit result.
- clk  in  1  system clock, all flops rising-edge
- reset_n  in  1  asynchronous, active-low reset
- state  in  1  current FSM state from the state register: 0 = IDLE, 1 = EXEC
- op_start  in  1  operand load request, honoured only in IDLE
- op_clear  in  1  synchronous clear, highest synchronous priority
- multiplicand  in  32  operand M
- multiplier  in  32  operand Q
- count  out  32  thermometer step counter, fed to `mul_next_state`
- result  out  64  product register; final when `count[31]`=1

## Operation
- Internal registers: `m_reg[31:0]`, `result[63:0]` (upper half A, lower half Q), `q_m1` (Booth guard bit), `count[31:0]`.
- Priority per rising edge: reset_n low (async) > op_clear > load > step > hold.
- Reset / op_clear: `count`=0, `result`=0, `m_reg`=0, `q_m1`=0.
- Load (state=0 & op_start=1): `m_reg`←multiplicand, `result`←{32'h0, multiplier}, `q_m1`←0, `count`←0.
- Step (state=1 & count[31]=0):
  - Decode {result[0], q_m1}: 01 → A+M; 10 → A−M; 00/11 → A unchanged.
  - Sum formed in 33 bits: A and M sign-extended by one bit; no overflow is possible, including M = 0x80000000.
  - New result = {sum[32], sum[32:1], sum[0], result[31:1]}, i.e. a 64-bit arithmetic right shift of the 65-bit {sum, Q}, discarding Q[0].
  - `q_m1`←old result[0]; `count`←{count[30:0], 1'b1}.
- Done hold (state=1 & count[31]=1): all registers hold; product stable until the next load, op_clear, or reset.
- state=0 without op_start: hold. op_start while state=1: ignored.
- Inputs `multiplicand` and `multiplier` are sampled only at load; later changes have no effect.

## Timing
- Reset values: count=32'h0, result=64'h0.
- Load edge L, then EXEC asserted by the FSM. Exactly 32 step edges occur; `count` reads 0x1, 0x3, …, 0xFFFFFFFF after steps 1…32.
- `count[31]` rises on the same edge that writes the final product. The result is valid from that edge, and the FSM observes done combinationally in that cycle.
- Latency from first EXEC edge to valid product: 32 cycles. There is no extra output register.
- op_clear asserted at any cycle, including mid-multiply: registers are zero after that edge. The FSM is responsible for returning to IDLE.
- reset_n low mid-multiply: immediate asynchronous clear, independent of clk.
- op_clear and op_start in the same IDLE cycle: clear wins, no load.

## Configuration
- `MUL_SIGNED_EN` defined: two's-complement operands, Booth recoding as above.
- `MUL_SIGNED_EN` undefined: unsigned shift-add.
  - Each step: if result[0]=1, sum = {1'b0,A}+{1'b0,M}; otherwise sum = {1'b0,A}.
  - Logical shift: new result = {sum[32:0], result[31:1]}.
  - `q_m1` is unused and held at 0.
- Cycle count, `count` behaviour and interface are identical in both builds.

## Test plan
- Signed build: M=6, Q=7, start, run EXEC → after 32 steps count=0xFFFFFFFF, result=64'h2A; hold 5 extra cycles, result unchanged.
- Signed build: M=0xFFFFFFFA (−6), Q=7 → result=64'hFFFFFFFFFFFFFFD6. M=Q=0x80000000 → result=64'h4000000000000000.
- op_clear pulsed after step 10 of M=123, Q=456 → next edge count=0, result=0; reload → result=56088 after 32 steps.
- reset_n low for 3 ns mid-step 17 (off clock edge) → count and result are 0 immediately; op_start asserted with state=1 at step 5 → ignored, final product correct.
- op_start and op_clear together in IDLE → no load, all zero. Multiplier input changed during EXEC → product reflects the loaded value.
- Unsigned build: M=Q=0xFFFFFFFF → result=64'hFFFFFFFE00000001. M=0, Q=0xFFFFFFFF → result=0. Both with count=0xFFFFFFFF.
